// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle chunked adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index counters keep at least one bit even when there is a single chunk.
  function automatic int idx_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit ripple-carry adder, time-multiplexed by multi_cycle_adder.
module chunk_adder #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);

  always_comb begin
    logic c;
    c = cin;
    s = '0;
    for (int i = 0; i < CHUNK; i++) begin
      s[i] = a[i] ^ b[i] ^ c;
      c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
    end
    cout = c;
  end

endmodule

// File: rtl/multi_cycle_adder.sv
// Unsigned WIDTH-bit adder computing CHUNK bits per cycle with valid/ready on both sides.
// Define ADDER_OVF_EN to add the registered two's-complement overflow output ovf.
module multi_cycle_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             Cout
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = idx_width(NCHUNK);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_cfg
    $error("multi_cycle_adder: WIDTH must be a positive multiple of CHUNK");
  end

  function automatic logic ovf_calc(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  state_t           state;
  logic [IW-1:0]    idx;
  logic             carry_p0;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [CHUNK-1:0] a_ch;
  logic [CHUNK-1:0] b_ch;
  logic [CHUNK-1:0] s_ch;
  logic             c_ch;

  // Stage p0: operands captured on the input handshake; data only, no reset
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      a_p0 <= A;
      b_p0 <= B;
    end
  end

  assign a_ch = a_p0[int'(idx)*CHUNK +: CHUNK];
  assign b_ch = b_p0[int'(idx)*CHUNK +: CHUNK];

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a    (a_ch),
    .b    (b_ch),
    .cin  (carry_p0),
    .s    (s_ch),
    .cout (c_ch)
  );

  // Stage p1: per-chunk result written into sum; the final chunk also lands Cout/ovf
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_p0  <= 1'b0;
      sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
`ifdef ADDER_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            idx      <= '0;
            carry_p0 <= Cin;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          sum[int'(idx)*CHUNK +: CHUNK] <= s_ch;
          carry_p0                      <= c_ch;
          if (idx == IW'(NCHUNK - 1)) begin
            idx       <= '0;
            Cout      <= c_ch;
`ifdef ADDER_OVF_EN
            ovf       <= ovf_calc(a_p0[WIDTH-1], b_p0[WIDTH-1], s_ch[CHUNK-1]);
`endif
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
